sram_controller: RTL and testbench



---
 rtl/sram_controller_pkg.sv | 20 ++
 rtl/sram_model.sv | 22 ++
 rtl/sram_controller.sv | 134 +++++++++++++
 tb/tb_sram_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 32-bit to 16-bit asynchronous SRAM bridge.
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sramState_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;
    localparam int unsigned DEFAULT_HALF_CYCLES = 3;
    localparam int unsigned DEFAULT_SRAM_AW     = 18;

    // Byte offset of a CPU address from the SRAM window base, wrapping mod 2^32.
    function automatic logic [31:0] byteOffset(input logic [31:0] addr, input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/sram_model.sv
// Behavioural asynchronous 16-bit SRAM: combinational read, write while weN is low.
module sram_model #(
    parameter int unsigned SRAM_AW = 18
) (
    input  logic               clk,
    input  logic [SRAM_AW-1:0] addr,
    input  logic               weN,
    input  logic [15:0]        dataIn,
    output logic [15:0]        dataOut
);

    logic [15:0] mem [0:(1 << SRAM_AW)-1];

    always_ff @(posedge clk) begin
        if (!weN) begin
            mem[addr] <= dataIn;
        end
    end

    assign dataOut = mem[addr];

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit word access into two timed 16-bit accesses on an asynchronous SRAM.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned HALF_CYCLES = DEFAULT_HALF_CYCLES,
    parameter int unsigned SRAM_AW     = DEFAULT_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_o,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int unsigned WAW = SRAM_AW - 1;
    localparam int unsigned CW  = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;

    sramState_e     state, nextState;
    logic [CW-1:0]  cnt, cntNext;
    logic [WAW-1:0] wordReg, wordNext;
    logic [31:0]    wdataReg, wdataNext;
    logic           opWrite, opWriteNext;
    logic [31:0]    readDataNext;
    logic [SRAM_AW-1:0] addrNext;
    logic [15:0]    dqNext;
    logic           oeNext, weNNext;
    logic           phaseEnd;

    // A pending request holds the pipeline even while the bridge is idle.
    assign ready = (state == DONE) | ((state == IDLE) & ~wr_en & ~rd_en);

    // Next-state and next-output logic; every register holds unless a phase moves it.
    always_comb begin
        nextState    = state;
        cntNext      = cnt;
        wordNext     = wordReg;
        wdataNext    = wdataReg;
        opWriteNext  = opWrite;
        readDataNext = read_data;
        addrNext     = sram_addr;
        dqNext       = sram_dq_o;
        oeNext       = sram_dq_oe;
        weNNext      = sram_we_n;
        phaseEnd     = (cnt == CW'(HALF_CYCLES - 1));

        case (state)
            IDLE: begin
                if (wr_en | rd_en) begin
                    nextState   = LOW;
                    cntNext     = '0;
                    wordNext    = WAW'(byteOffset(address, BASE_ADDR) >> 2);
                    wdataNext   = write_data;
                    opWriteNext = wr_en;
                    addrNext    = {wordNext, 1'b0};
                    if (wr_en) begin
                        dqNext = write_data[15:0];
                    end
                    oeNext      = wr_en;
                    weNNext     = ~wr_en;
                end
            end
            LOW: begin
                if (phaseEnd) begin
                    nextState = HIGH;
                    cntNext   = '0;
                    if (!opWrite) begin
                        readDataNext[15:0] = sram_dq_i;
                    end else begin
                        dqNext = wdataReg[31:16];
                    end
                    addrNext  = {wordReg, 1'b1};
                end else begin
                    cntNext = cnt + CW'(1);
                end
            end
            HIGH: begin
                if (phaseEnd) begin
                    nextState = DONE;
                    cntNext   = '0;
                    if (!opWrite) begin
                        readDataNext[31:16] = sram_dq_i;
                    end
                    oeNext    = 1'b0;
                    weNNext   = 1'b1;
                end else begin
                    cntNext = cnt + CW'(1);
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wordReg    <= '0;
            wdataReg   <= '0;
            opWrite    <= 1'b0;
            read_data  <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
        end else begin
            state      <= nextState;
            cnt        <= cntNext;
            wordReg    <= wordNext;
            wdataReg   <= wdataNext;
            opWrite    <= opWriteNext;
            read_data  <= readDataNext;
            sram_addr  <= addrNext;
            sram_dq_o  <= dqNext;
            sram_dq_oe <= oeNext;
            sram_we_n  <= weNNext;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller at HALF_CYCLES=3 and HALF_CYCLES=1.
module tb_sram_controller;
    import sram_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrEn [2];
    logic        rdEn [2];
    logic [31:0] address [2];
    logic [31:0] writeData [2];
    logic [31:0] readData [2];
    logic        ready [2];
    logic [17:0] sramAddr [2];
    logic [15:0] sramDqO [2];
    logic [15:0] sramDqI [2];
    logic        sramDqOe [2];
    logic        sramWeN [2];

    int checks = 0;
    int errors = 0;

    logic [31:0] sb [$];
    logic [17:0] addrSeq [$];
    logic [15:0] refMem [int];
    logic [31:0] lastRead [2];

    always #5 clk = ~clk;

    sram_controller #(.HALF_CYCLES(3)) u_dut0 (
        .clk(clk), .rst(rst), .wr_en(wrEn[0]), .rd_en(rdEn[0]), .address(address[0]),
        .write_data(writeData[0]), .read_data(readData[0]), .ready(ready[0]),
        .sram_addr(sramAddr[0]), .sram_dq_o(sramDqO[0]), .sram_dq_i(sramDqI[0]),
        .sram_dq_oe(sramDqOe[0]), .sram_we_n(sramWeN[0])
    );
    sram_model #(.SRAM_AW(18)) u_mem0 (
        .clk(clk), .addr(sramAddr[0]), .weN(sramWeN[0]), .dataIn(sramDqO[0]), .dataOut(sramDqI[0])
    );

    sram_controller #(.HALF_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_en(wrEn[1]), .rd_en(rdEn[1]), .address(address[1]),
        .write_data(writeData[1]), .read_data(readData[1]), .ready(ready[1]),
        .sram_addr(sramAddr[1]), .sram_dq_o(sramDqO[1]), .sram_dq_i(sramDqI[1]),
        .sram_dq_oe(sramDqOe[1]), .sram_we_n(sramWeN[1])
    );
    sram_model #(.SRAM_AW(18)) u_mem1 (
        .clk(clk), .addr(sramAddr[1]), .weN(sramWeN[1]), .dataIn(sramDqO[1]), .dataOut(sramDqI[1])
    );

    function automatic int wordIdx(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'((off >> 2) & 32'h0001_FFFF);
    endfunction

    function automatic logic [31:0] refWord(input int which, input int w);
        int k0, k1;
        k0 = which * (1 << 20) + 2 * w;
        k1 = k0 + 1;
        return {refMem.exists(k1) ? refMem[k1] : 16'h0, refMem.exists(k0) ? refMem[k0] : 16'h0};
    endfunction

    // Waits until ready rises; cycle 1 is the cycle in which the request was presented.
    task automatic waitReady(input int which, output int cycles, output bit done);
        cycles = 1;
        done   = 1'b0;
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (ready[which] === 1'b1) done = 1'b1;
        end
    endtask

    // One complete word access with per-cycle bus checks and scoreboard comparison at DONE.
    task automatic doAccess(input int which, input bit isWr, input bit isRd, input logic [31:0] addr,
                            input logic [31:0] data, input int hc, input string name);
        int cycles, w, half;
        bit done;
        logic [31:0] expRd;
        logic [15:0] expDq;
        w = wordIdx(addr);
        if (isWr) begin
            refMem[which * (1 << 20) + 2 * w]     = data[15:0];
            refMem[which * (1 << 20) + 2 * w + 1] = data[31:16];
            sb.push_back(lastRead[which]);
        end else begin
            expRd = refWord(which, w);
            sb.push_back(expRd);
            lastRead[which] = expRd;
        end
        addrSeq.delete();
        @(negedge clk);
        wrEn[which] = isWr; rdEn[which] = isRd; address[which] = addr; writeData[which] = data;
        #1;
        checks++;
        if (ready[which] !== 1'b0) begin
            errors++; $display("FAIL %s ready_in_request_cycle got %b want 0", name, ready[which]);
        end
        cycles = 1;
        done = 1'b0;
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (ready[which] === 1'b1) begin
                done = 1'b1;
            end else begin
                addrSeq.push_back(sramAddr[which]);
                half  = (cycles - 2 < hc) ? 0 : 1;
                expDq = half ? data[31:16] : data[15:0];
                checks++;
                if (sramAddr[which] !== 18'(2 * w + half) ||
                    (isWr && (sramWeN[which] !== 1'b0 || sramDqOe[which] !== 1'b1 || sramDqO[which] !== expDq)) ||
                    (!isWr && (sramWeN[which] !== 1'b1 || sramDqOe[which] !== 1'b0))) begin
                    errors++;
                    $display("FAIL %s bus_cycle%0d got addr=%h we_n=%b oe=%b dq=%h want addr=%h we_n=%b oe=%b dq=%h",
                             name, cycles, sramAddr[which], sramWeN[which], sramDqOe[which], sramDqO[which],
                             18'(2 * w + half), !isWr, isWr, expDq);
                end
            end
        end
        checks++;
        if (!done || cycles != 2 * hc + 2) begin
            errors++; $display("FAIL %s latency got %0d want %0d", name, cycles, 2 * hc + 2);
        end
        checks++;
        if (sramWeN[which] !== 1'b1 || sramDqOe[which] !== 1'b0) begin
            errors++; $display("FAIL %s done_bus got we_n=%b oe=%b want 1 0", name, sramWeN[which], sramDqOe[which]);
        end
        expRd = sb.pop_front();
        checks++;
        if (readData[which] !== expRd) begin
            errors++; $display("FAIL %s read_data got %h want %h", name, readData[which], expRd);
        end
        wrEn[which] = 1'b0; rdEn[which] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wrEn[i] = 1'b0; rdEn[i] = 1'b0; address[i] = '0; writeData[i] = '0; lastRead[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (readData[i] !== 32'h0 || sramAddr[i] !== 18'h0 || sramDqO[i] !== 16'h0 ||
                sramDqOe[i] !== 1'b0 || sramWeN[i] !== 1'b1 || ready[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset%0d got rd=%h addr=%h dq=%h oe=%b we_n=%b ready=%b want 0 0 0 0 1 1",
                         i, readData[i], sramAddr[i], sramDqO[i], sramDqOe[i], sramWeN[i], ready[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic checkMem(input int which, input int idx, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++; $display("FAIL model%0d[%0d] got %h want %h", which, idx, got, want);
        end
    endtask

    task automatic test_write_read();
        doAccess(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 3, "write1024");
        checkMem(0, 0, u_mem0.mem[0], 16'hBEEF);
        checkMem(0, 1, u_mem0.mem[1], 16'hDEAD);
        doAccess(0, 1'b0, 1'b1, 32'd1024, 32'h0, 3, "read1024");
    endtask

    task automatic test_address_map();
        doAccess(0, 1'b1, 1'b0, 32'd1036, 32'h12345678, 3, "write1036");
        checkMem(0, 6, u_mem0.mem[6], 16'h5678);
        checkMem(0, 7, u_mem0.mem[7], 16'h1234);
        doAccess(0, 1'b0, 1'b1, 32'd1037, 32'hFFFF_FFFF, 3, "read1037");
    endtask

    task automatic test_simultaneous();
        doAccess(0, 1'b1, 1'b1, 32'd1028, 32'hA5A5A5A5, 3, "wr_rd_both");
        checkMem(0, 2, u_mem0.mem[2], 16'hA5A5);
        checkMem(0, 3, u_mem0.mem[3], 16'hA5A5);
    endtask

    task automatic test_back_to_back();
        int cycles;
        bit done;
        logic [31:0] expRd;
        doAccess(0, 1'b1, 1'b0, 32'd1032, 32'h0BADF00D, 3, "write1032");
        sb.push_back(refWord(0, wordIdx(32'd1024)));
        sb.push_back(refWord(0, wordIdx(32'd1032)));
        @(negedge clk);
        rdEn[0] = 1'b1; address[0] = 32'd1024;
        waitReady(0, cycles, done);
        checks++;
        if (!done || cycles != 8) begin
            errors++; $display("FAIL b2b_first_latency got %0d want 8", cycles);
        end
        expRd = sb.pop_front();
        checks++;
        if (readData[0] !== expRd) begin
            errors++; $display("FAIL b2b_first_data got %h want %h", readData[0], expRd);
        end
        address[0] = 32'd1032;
        @(negedge clk);
        checks++;
        if (ready[0] !== 1'b0) begin
            errors++; $display("FAIL b2b_ready_gap got %b want 0", ready[0]);
        end
        waitReady(0, cycles, done);
        checks++;
        if (!done || cycles != 8) begin
            errors++; $display("FAIL b2b_second_latency got %0d want 8", cycles);
        end
        expRd = sb.pop_front();
        lastRead[0] = expRd;
        checks++;
        if (readData[0] !== expRd) begin
            errors++; $display("FAIL b2b_second_data got %h want %h", readData[0], expRd);
        end
        rdEn[0] = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        wrEn[0] = 1'b1; address[0] = 32'd1040; writeData[0] = 32'h55AA33CC;
        repeat (5) @(negedge clk);
        checks++;
        if (u_dut0.state !== HIGH) begin
            errors++; $display("FAIL midreset_precondition state got %0d want %0d", u_dut0.state, HIGH);
        end
        rst = 1'b1;
        wrEn[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (u_dut0.state !== IDLE || sramWeN[0] !== 1'b1 || sramDqOe[0] !== 1'b0 ||
            readData[0] !== 32'h0 || ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset got state=%0d we_n=%b oe=%b rd=%h ready=%b want 0 1 0 0 1",
                     u_dut0.state, sramWeN[0], sramDqOe[0], readData[0], ready[0]);
        end
        rst = 1'b0;
        lastRead[0] = '0;
        lastRead[1] = '0;
    endtask

    task automatic test_half_cycles_one();
        doAccess(1, 1'b1, 1'b0, 32'd1024, 32'hCAFEF00D, 1, "hc1_write");
        doAccess(1, 1'b0, 1'b1, 32'd1024, 32'h0, 1, "hc1_read");
        checks++;
        if (addrSeq.size() != 2 || addrSeq[0] !== 18'd0 || addrSeq[1] !== 18'd1) begin
            errors++;
            $display("FAIL hc1_addr_seq got size=%0d first=%h second=%h want 2 0 1", addrSeq.size(),
                     addrSeq.size() > 0 ? addrSeq[0] : 18'h3FFFF, addrSeq.size() > 1 ? addrSeq[1] : 18'h3FFFF);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_address_map();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_access();
        test_half_cycles_one();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

endmodule
